// File: rtl/norm_out_if.sv
// norm_out_if: handshake/data bundle for the norm_out de-normalizer.
//   en, start    - block enable and conversion request (master -> slave)
//   frac         - S+8 bit unsigned fixed-point multiplier (master -> slave)
//   scale        - 20 bit unsigned full-scale value (master -> slave)
//   result, ovf  - saturated de-normalized value and saturation flag (slave -> master)
//   ready, done  - ready to accept start / one-cycle completion pulse (slave -> master)
interface norm_out_if #(
  parameter int S = 8
);
  logic          en;
  logic          start;
  logic [S+7:0]  frac;
  logic [19:0]   scale;
  logic [19:0]   result;
  logic          ovf;
  logic          ready;
  logic          done;

  modport master (
    output en, start, frac, scale,
    input  result, ovf, ready, done
  );

  modport slave (
    input  en, start, frac, scale,
    output result, ovf, ready, done
  );
endinterface

// File: rtl/norm_out.sv
// norm_out: de-normalizes a fixed-point fraction against a 20-bit full scale.
//   result = floor(frac * scale / 2^D), saturated to 20'hFFFFF (ovf flags saturation).
//   The product is formed by a serial shift-add multiplier, one bit per enabled
//   cycle; done pulses S+9 enabled cycles after start is accepted.
// Ports:
//   MHz10 - system clock (rising edge)
//   rst   - asynchronous active-high reset
//   bus   - norm_out_if slave modport (en, start, frac, scale, result, ovf, ready, done)
// Build option:
//   NORM_OUT_ROUND_EN - when defined, adds 2^(D-1) before the shift by D
//                       (round half up); otherwise the product is truncated.
module norm_out #(
  parameter int S = 8,
  parameter int D = 8
) (
  input  logic       MHz10,
  input  logic       rst,
  norm_out_if.slave  bus
);

  localparam int FW = S + 8;             // multiplier width
  localparam int AW = FW + 20;           // accumulator / product width
  localparam int CW = $clog2(FW + 1);    // iteration counter width

  typedef enum logic {READY, MULT} state_t;

  state_t         state;
  logic [FW-1:0]  mplier;
  logic [AW-1:0]  mcand;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  cnt;
  logic [19:0]    result_r;
  logic           ovf_r;
  logic           done_r;

  // One extra bit so a rounding increment can never wrap the product.
  logic [AW:0]    rounded;
  logic [AW:0]    shifted;
  logic           sat;
  logic [19:0]    sat_res;

`ifdef NORM_OUT_ROUND_EN
  localparam logic [AW:0] RND = (AW+1)'((2 ** D) >> 1);
  always_comb rounded = {1'b0, acc} + RND;
`else
  always_comb rounded = {1'b0, acc};
`endif

  always_comb begin
    shifted = rounded >> D;
    sat     = |shifted[AW:20];
    sat_res = sat ? 20'hFFFFF : shifted[19:0];
  end

  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      state    <= READY;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.en) begin
        case (state)
          READY: begin
            if (bus.start) begin
              mplier <= bus.frac;
              mcand  <= AW'(bus.scale);
              acc    <= '0;
              cnt    <= CW'(FW);
              state  <= MULT;
            end
          end
          MULT: begin
            if (cnt != '0) begin
              if (mplier[0])
                acc <= acc + mcand;
              mplier <= mplier >> 1;
              mcand  <= mcand << 1;
              cnt    <= cnt - CW'(1);
            end else begin
              // Counter exhausted: the accumulator holds the full product.
              result_r <= sat_res;
              ovf_r    <= sat;
              done_r   <= 1'b1;
              state    <= READY;
            end
          end
          default: state <= READY;
        endcase
      end
    end
  end

  assign bus.ready  = (state == READY) && bus.en;
  assign bus.result = result_r;
  assign bus.ovf    = ovf_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_norm_out.sv
// tb_norm_out: scoreboard bench for norm_out. Accepted starts push the
// arithmetic expectation (and the enabled-cycle count at which done is due)
// into a queue; an independent monitor pops and compares on every done.
module tb_norm_out;

  localparam int S = 8;
  localparam int D = 8;
  localparam int LAT = S + 9;

  logic MHz10 = 1'b0;
  logic rst   = 1'b1;

  norm_out_if #(.S(S)) bus ();

  norm_out #(.S(S), .D(D)) dut (
    .MHz10 (MHz10),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 MHz10 = ~MHz10;

  typedef struct {
    logic [19:0] res;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned ncyc  = 0;
  logic [19:0] last_res = '0;
  logic        last_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the full-precision product.
  function automatic logic [20:0] model(input logic [S+7:0] f, input logic [19:0] s);
    longint unsigned p;
    p = longint'(f) * longint'(s);
`ifdef NORM_OUT_ROUND_EN
    p = p + (longint'(1) << (D - 1));
`endif
    p = p >> D;
    if (p > 64'hFFFFF) return {1'b1, 20'hFFFFF};
    return {1'b0, p[19:0]};
  endfunction

  // Enabled, non-reset clock edges.
  always @(posedge MHz10) if (!rst && bus.en) ncyc++;

  // Stimulus side of the scoreboard: a start seen with ready high is accepted next edge.
  always @(negedge MHz10) begin
    if (!rst && bus.ready && bus.start) begin
      exp_t e;
      logic [20:0] m;
      m     = model(bus.frac, bus.scale);
      e.res = m[19:0];
      e.ovf = m[20];
      e.due = ncyc + 1 + LAT;
      q.push_back(e);
    end
  end

  // Monitor: compare on done, otherwise outputs must hold.
  always @(negedge MHz10) begin
    if (bus.done) begin
      check("done_has_expectation", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
        check("latency_en_cycles", ncyc, e.due);
        last_res = e.res;
        last_ovf = e.ovf;
      end
    end else begin
      check("hold_result", 32'(bus.result), 32'(last_res));
      check("hold_ovf", 32'(bus.ovf), 32'(last_ovf));
    end
  end

  task automatic step();
    @(posedge MHz10);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    q.delete();
    last_res = '0;
    last_ovf = 1'b0;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Issue a start and hold it until the accept has been recorded.
  task automatic issue(input logic [S+7:0] f, input logic [19:0] s);
    int unsigned i;
    bus.frac  = f;
    bus.scale = s;
    bus.start = 1'b1;
    for (i = 0; i < 50; i++) begin
      step();
      if (q.size() != 0) break;
    end
    check("start_accepted", 32'(q.size() != 0), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned i;
    for (i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      step();
    end
    check("completion_within_budget", 32'(q.size()), 32'd0);
  endtask

  task automatic expect_out(input string name, input logic [19:0] r, input logic o);
    @(negedge MHz10);
    check({name, "_result"}, 32'(bus.result), 32'(r));
    check({name, "_ovf"}, 32'(bus.ovf), 32'(o));
    step();
  endtask

  initial begin
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.frac  = '0;
    bus.scale = '0;
    do_reset(3);

    // Reset state.
    @(negedge MHz10);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd1);
    step();

    // Basic value and saturation corners.
    issue(16'h0080, 20'd1000);   wait_idle(40); expect_out("half_of_1000", 20'd500, 1'b0);
    issue(16'h0100, 20'hFFFFF);  wait_idle(40); expect_out("unity_full", 20'hFFFFF, 1'b0);
    issue(16'hFF00, 20'h10000);  wait_idle(40); expect_out("saturate", 20'hFFFFF, 1'b1);
    issue(16'h0001, 20'd200);    wait_idle(40);
`ifdef NORM_OUT_ROUND_EN
    expect_out("round_small", 20'd1, 1'b0);
`else
    expect_out("trunc_small", 20'd0, 1'b0);
`endif
    issue(16'h0000, 20'hABCDE);  wait_idle(40); expect_out("frac_zero", 20'd0, 1'b0);
    issue(16'h1234, 20'd0);      wait_idle(40); expect_out("scale_zero", 20'd0, 1'b0);

    // Restart attempt and operand change mid-conversion.
    issue(16'h0180, 20'd4000);
    repeat (4) step();
    bus.start = 1'b1;
    bus.frac  = 16'hFFFF;
    bus.scale = 20'h12345;
    repeat (3) step();
    bus.start = 1'b0;
    wait_idle(40);
    expect_out("restart_ignored", 20'd6000, 1'b0);

    // Enable dropped for 4 cycles mid-conversion.
    issue(16'h0240, 20'd800);
    repeat (5) step();
    bus.en = 1'b0;
    @(negedge MHz10);
    check("ready_low_when_disabled", 32'(bus.ready), 32'd0);
    repeat (4) step();
    bus.en = 1'b1;
    wait_idle(40);
    expect_out("en_stall", 20'd1800, 1'b0);

    // Reset mid-conversion aborts with no done.
    issue(16'hFFFF, 20'hFFFFF);
    repeat (5) step();
    do_reset(2);
    @(negedge MHz10);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    check("ready_after_release", 32'(bus.ready), 32'd1);
    step();
    issue(16'h0300, 20'd1000);   wait_idle(40); expect_out("after_abort", 20'd3000, 1'b0);

    // Randomized traffic: enable gaps, operand churn, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      bus.en    = ($urandom_range(0, 7) != 0);
      bus.start = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      bus.frac  = (sel == 0) ? '0 : (sel == 1) ? '1 : (S+8)'($urandom);
      sel = $urandom_range(0, 9);
      bus.scale = (sel == 0) ? '0 : (sel == 1) ? '1 : 20'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step();
      end
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    wait_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/norm_out.md
NORM_OUT -- requirements
Module: norm_out

Interface
REQ-001 Parameter S, default 8, integer width of the fraction operand (operand is S+8 bits wide).
REQ-002 Parameter D, default 8, number of fractional bits in the fraction operand.
REQ-003 MHz10  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  block enable; when low, all state holds and no progress is made.
REQ-006 start  input  1  request to begin a conversion; sampled only when ready is high.
REQ-007 frac  input  S+8  unsigned fixed-point multiplier (S integer bits, D fractional bits), e.g. the quotient produced by the normalizing divider.
REQ-008 scale  input  20  unsigned full-scale value to de-normalize against.
REQ-009 result  output  20  registered de-normalized value, floor(frac*scale / 2^D), saturated.
REQ-010 ovf  output  1  registered flag, high when result saturated.
REQ-011 ready  output  1  combinational, high when state is READY and en is high.
REQ-012 done  output  1  registered one-cycle pulse marking a new result/ovf.

Function
REQ-013 The block SHALL implement a two-state FSM: READY and MULT.
REQ-014 In READY with en and start high, the block SHALL latch frac and scale, clear a 36-bit accumulator, load the iteration counter with S+8, and go to MULT.
REQ-015 In MULT, each enabled cycle SHALL perform one shift-add step: if the current multiplier LSB is 1, add the shifted scale to the accumulator; shift multiplier right and scale left; decrement the counter.
REQ-016 When the counter reaches 0, the block SHALL register result and ovf, assert done for exactly the following cycle, and return to READY.
REQ-017 Latency: done SHALL be high exactly S+9 enabled cycles after the start-accept edge (17 with defaults).
REQ-018 The final product SHALL be shifted right by D; if any bit above bit 19 remains set, result SHALL be 20'hFFFFF and ovf 1, else ovf 0.
REQ-019 start while in MULT SHALL be ignored; operands are not re-sampled mid-conversion.
REQ-020 Changes on frac/scale after start-accept SHALL NOT affect the in-flight result.
REQ-021 When en is low, FSM, counter, accumulator, result, ovf SHALL hold; done SHALL be 0; ready SHALL be 0.
REQ-022 result and ovf SHALL hold their last value until the next completion.
REQ-023 frac = 0 or scale = 0 SHALL yield result 0, ovf 0, with normal latency.

Reset
REQ-024 While rst is high: state = READY, result = 0, ovf = 0, done = 0, accumulator, counter and latched operands = 0.
REQ-025 rst asserted mid-conversion SHALL abort it with no done pulse; ready SHALL rise the first cycle after rst release (if en high).

Configuration
REQ-026 Macro NORM_OUT_ROUND_EN: when defined, 2^(D-1) SHALL be added to the product before the right shift by D (round half up, saturation applied afterwards); when undefined, the result SHALL be truncated with no rounding logic present.

Verification
REQ-027 frac=16'h0080, scale=1000, start -> 17 cycles later done=1, result=500, ovf=0.
REQ-028 frac=16'h0100, scale=20'hFFFFF -> result=20'hFFFFF, ovf=0; frac=16'hFF00, scale=20'h10000 -> result=20'hFFFFF, ovf=1.
REQ-029 frac=16'h0001, scale=200 -> result=0 without NORM_OUT_ROUND_EN, result=1 with it.
REQ-030 Start conversion, pulse start again and change frac at cycle 5 -> single done, result from the original operands.
REQ-031 Drop en for 4 cycles mid-MULT -> done delayed by exactly 4 cycles, result unchanged.
REQ-032 Assert rst at MULT cycle 6 -> result=0, ovf=0, no done; after release, ready=1 and a new conversion completes correctly.
